// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one access at a time to a word-wide req/ack data memory,
// splitting word-crossing accesses in two and returning extended load data.
module mem_stage_lsu #(
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-3:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    localparam int WA_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              sext_q, sext_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        size_q, size_d;
    logic              cross_q, cross_d;
    logic              err_q, err_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic [7:0]        mask_q, mask_d;
    logic [63:0]       sdata_q, sdata_d;
    logic [31:0]       buf_lo_q, buf_lo_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic [2:0]        req_size;
    logic [3:0]        req_lanes;
    logic [3:0]        req_end;
    logic              req_cross;
    logic              req_illegal;

    // Shift the two-word read buffer down to the access offset and extend.
    function automatic logic [31:0] extract(input logic [63:0] b, input logic [1:0] off,
                                            input logic [2:0] size, input logic sext);
        logic [31:0] s;
        s = b[{off, 3'b000} +: 32];
        case (size)
            3'd1:    extract = {{24{sext & s[7]}}, s[7:0]};
            3'd2:    extract = {{16{sext & s[15]}}, s[15:0]};
            default: extract = s;
        endcase
    endfunction

    always_comb begin
        req_size  = 3'd0;
        req_lanes = 4'b0000;
        case (req_funct3[1:0])
            2'b00: begin
                req_size  = 3'd1;
                req_lanes = 4'b0001;
            end
            2'b01: begin
                req_size  = 3'd2;
                req_lanes = 4'b0011;
            end
            2'b10: begin
                req_size  = 3'd4;
                req_lanes = 4'b1111;
            end
            default: ;
        endcase
        req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        req_end     = {2'b00, req_addr[1:0]} + {1'b0, req_size};
        req_cross   = (req_end > 4'd4);
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        sext_d      = sext_q;
        off_d       = off_q;
        size_d      = size_q;
        cross_d     = cross_q;
        err_d       = err_q;
        waddr_d     = waddr_q;
        mask_d      = mask_q;
        sdata_d     = sdata_q;
        buf_lo_d    = buf_lo_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    sext_d   = ~req_funct3[2];
                    off_d    = req_addr[1:0];
                    size_d   = req_size;
                    cross_d  = req_cross;
                    waddr_d  = req_addr[ADDR_W-1:2];
                    mask_d   = {4'b0000, req_lanes} << req_addr[1:0];
                    sdata_d  = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
                    buf_lo_d = '0;
                    err_d    = req_illegal || (req_cross && !SPLIT_MISALIGNED);
                    if (err_d) begin
                        state_d     = S_RESP;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = S_ACC0;
                    end
                end
            end
            S_ACC0: begin
                if (dmem_ack) begin
                    buf_lo_d = dmem_rdata;
                    if (cross_q) begin
                        state_d = S_ACC1;
                    end else begin
                        state_d     = S_RESP;
                        rsp_rdata_d = we_q ? 32'h0
                                           : extract({32'b0, dmem_rdata}, off_q, size_q, sext_q);
                    end
                end
            end
            S_ACC1: begin
                if (dmem_ack) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = we_q ? 32'h0
                                       : extract({dmem_rdata, buf_lo_q}, off_q, size_q, sext_q);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port is decoded from state and captured fields, so it cannot move during an ack wait.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_addr  = '0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'h0;
        case (state_q)
            S_ACC0: begin
                dmem_req   = 1'b1;
                dmem_addr  = waddr_q;
                dmem_be    = mask_q[3:0];
                dmem_wdata = sdata_q[31:0];
            end
            S_ACC1: begin
                dmem_req   = 1'b1;
                dmem_addr  = waddr_q + {{(WA_W-1){1'b0}}, 1'b1};
                dmem_be    = mask_q[7:4];
                dmem_wdata = sdata_q[63:32];
            end
            default: ;
        endcase
        dmem_we = dmem_req & we_q;
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = (state_q == S_RESP) & err_q;
    assign rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= 3'd0;
            cross_q     <= 1'b0;
            err_q       <= 1'b0;
            waddr_q     <= '0;
            mask_q      <= 8'h00;
            sdata_q     <= 64'h0;
            buf_lo_q    <= 32'h0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            sext_q      <= sext_d;
            off_q       <= off_d;
            size_q      <= size_d;
            cross_q     <= cross_d;
            err_q       <= err_d;
            waddr_q     <= waddr_d;
            mask_q      <= mask_d;
            sdata_q     <= sdata_d;
            buf_lo_q    <= buf_lo_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboarded bench for mem_stage_lsu: byte-level reference memory, random-latency responder,
// directed latency/lane checks, plus a second instance built without misaligned splitting.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;

    logic        req_valid0, req_ready0, req_we0;
    logic [2:0]  req_funct30;
    logic [31:0] req_addr0, req_wdata0;
    logic        rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;
    logic        dmem_req0, dmem_we0, dmem_ack0;
    logic [29:0] dmem_addr0;
    logic [3:0]  dmem_be0;
    logic [31:0] dmem_wdata0, dmem_rdata0;

    mem_stage_lsu #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    mem_stage_lsu #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_funct3(req_funct30), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .dmem_req(dmem_req0), .dmem_we(dmem_we0), .dmem_addr(dmem_addr0), .dmem_be(dmem_be0),
        .dmem_wdata(dmem_wdata0), .dmem_ack(dmem_ack0), .dmem_rdata(dmem_rdata0)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { logic we; logic [29:0] addr; logic [3:0] be; logic [31:0] wdata; } acc_t;
    rsp_t exp_q[$];
    acc_t acc_log[$];

    // Responder memory is word-addressed; the reference memory is byte-addressed and independent.
    logic [31:0] rmem [logic [29:0]];
    logic [7:0]  gmem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rmem_rd(input logic [29:0] w);
        return rmem.exists(w) ? rmem[w] : init_word(w);
    endfunction

    function automatic logic [7:0] gbyte(input logic [31:0] a);
        logic [31:0] w;
        if (gmem.exists(a)) return gmem[a];
        w = init_word(a[31:2]);
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic preload(input logic [29:0] w, input logic [31:0] v);
        rmem[w] = v;
        for (int i = 0; i < 4; i++) gmem[{w, 2'b00} + 32'(i)] = v[8*i +: 8];
    endtask

    // Reference: byte-by-byte access on the flat byte memory with arithmetic extension.
    task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd);
        rsp_t r;
        int size;
        logic [63:0] v;
        logic [63:0] lim;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        r.rdata = 32'h0;
        r.err   = 1'b0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3[2])) begin
            r.err = 1'b1;
        end else if (we) begin
            for (int i = 0; i < size; i++) gmem[addr + 32'(i)] = wd[8*i +: 8];
        end else begin
            v = 64'h0;
            for (int i = 0; i < size; i++) v = v + (64'(gbyte(addr + 32'(i))) << (8*i));
            lim = 64'd1 << (8*size);
            if (!f3[2] && v >= lim / 2) v = v - lim;
            r.rdata = v[31:0];
        end
        exp_q.push_back(r);
    endtask

    int   fixed_delay = -1;
    int   wait_left;
    bit   in_acc = 1'b0;
    acc_t cur;

    always @(negedge clk) begin
        if (!rst_n || !dmem_req) begin
            dmem_ack = 1'b0;
            in_acc   = 1'b0;
        end else begin
            if (!in_acc) begin
                in_acc    = 1'b1;
                cur.we    = dmem_we;
                cur.addr  = dmem_addr;
                cur.be    = dmem_be;
                cur.wdata = dmem_wdata;
                wait_left = (fixed_delay < 0) ? int'($urandom_range(0, 2)) : fixed_delay;
            end else begin
                check("dmem_ctl_stable", {dmem_we, dmem_addr, dmem_be}, {cur.we, cur.addr, cur.be});
                check("dmem_wdata_stable", dmem_wdata, cur.wdata);
            end
            if (wait_left == 0) begin
                logic [31:0] w;
                w = rmem_rd(cur.addr);
                dmem_rdata = w;
                if (cur.we) begin
                    for (int i = 0; i < 4; i++)
                        if (cur.be[i]) w[8*i +: 8] = cur.wdata[8*i +: 8];
                    rmem[cur.addr] = w;
                end
                dmem_ack = 1'b1;
                acc_log.push_back(cur);
                in_acc = 1'b0;
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = $urandom();
                wait_left--;
            end
        end
    end

    int n_rsp = 0;
    int last_rsp_cyc = 0;
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            rsp_t e;
            last_rsp_cyc = cyc;
            n_rsp++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b, expected no response", rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    int acc_cyc;

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit push);
        int guard;
        @(posedge clk);
        #1;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) check("req_ready_timeout", 0, 1);
        acc_cyc = cyc;
        if (push) model_push(we, f3, addr, wd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n_before);
        int guard;
        guard = 0;
        while (n_rsp == n_before && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) check("rsp_timeout", 0, 1);
    endtask

    task automatic directed(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int exp_lat, input int exp_nacc);
        int n0;
        acc_log.delete();
        n0 = n_rsp;
        issue(we, f3, addr, wd, 1'b1);
        wait_rsp(n0);
        check("latency", last_rsp_cyc - acc_cyc, exp_lat);
        check("access_count", acc_log.size(), exp_nacc);
    endtask

    task automatic check_acc(input int idx, input logic we, input logic [29:0] a,
                             input logic [3:0] be, input logic [31:0] wd);
        if (idx < acc_log.size()) begin
            check("acc_addr", acc_log[idx].addr, a);
            check("acc_be", acc_log[idx].be, be);
            check("acc_we", acc_log[idx].we, we);
            if (we) check("acc_wdata", acc_log[idx].wdata, wd);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_dmem"}, {dmem_req, dmem_we, dmem_be}, 0);
        check({tag, "_dmem_addr"}, dmem_addr, 0);
        check({tag, "_dmem_wdata"}, dmem_wdata, 0);
        check({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
    endtask

    logic [2:0] f3tab [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd1, 3'd3, 3'd6, 3'd7};
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_funct30 = 3'd0; req_addr0 = 32'h0; req_wdata0 = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        dmem_ack0 = 1'b1; dmem_rdata0 = 32'h8765_4321;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while ACC0 waits for ack: the access is dropped without a response.
        fixed_delay = 10;
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
        check("acc0_req_before_reset", dmem_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_acc_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("no_rsp_after_reset", rsp_valid, 0);
        end

        fixed_delay = 0;
        preload(30'h40, 32'hDEAD_BEEF);
        directed(1'b0, 3'd2, 32'h100, 32'h0, 2, 1);
        check_acc(0, 1'b0, 30'h40, 4'b1111, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

        preload(30'h40, 32'h8012_3456);
        directed(1'b0, 3'd0, 32'h103, 32'h0, 2, 1);
        check_acc(0, 1'b0, 30'h40, 4'b1000, 32'h0);
        directed(1'b0, 3'd4, 32'h103, 32'h0, 2, 1);
        check_acc(0, 1'b0, 30'h40, 4'b1000, 32'h0);

        directed(1'b1, 3'd2, 32'h0FE, 32'h1122_3344, 3, 2);
        check_acc(0, 1'b1, 30'h3F, 4'b1100, 32'h3344_0000);
        check_acc(1, 1'b1, 30'h40, 4'b0011, 32'h0000_1122);
        directed(1'b0, 3'd2, 32'h0FE, 32'h0, 3, 2);

        fixed_delay = 2;
        preload(30'h0, 32'hAB00_0000);
        preload(30'h1, 32'h0000_00CD);
        directed(1'b0, 3'd1, 32'h003, 32'h0, 7, 2);
        check_acc(0, 1'b0, 30'h0, 4'b1000, 32'h0);
        check_acc(1, 1'b0, 30'h1, 4'b0001, 32'h0);

        fixed_delay = 0;
        directed(1'b1, 3'd4, 32'h20, 32'h55, 1, 0);
        directed(1'b0, 3'd7, 32'h24, 32'h0, 1, 0);
        directed(1'b1, 3'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 3, 2);
        check_acc(0, 1'b1, 30'h3FFF_FFFF, 4'b1100, 32'hF00D_0000);
        check_acc(1, 1'b1, 30'h0, 4'b0011, 32'h0000_CAFE);

        // Instance without splitting: crossing access errors out, aligned one goes to memory.
        @(posedge clk);
        #1;
        req_we0 = 1'b0; req_funct30 = 3'd2; req_addr0 = 32'h001; req_valid0 = 1'b1;
        check("ns_ready", req_ready0, 1);
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        check("ns_err_rsp", {rsp_valid0, rsp_err0}, 2'b11);
        check("ns_err_rdata", rsp_rdata0, 0);
        check("ns_err_no_mem", dmem_req0, 0);
        @(posedge clk);
        #1;
        check("ns_err_pulse", rsp_valid0, 0);
        req_funct30 = 3'd5; req_addr0 = 32'h008; req_valid0 = 1'b1;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        check("ns_acc0", {dmem_req0, dmem_we0, dmem_be0}, {1'b1, 1'b0, 4'b0011});
        check("ns_acc0_addr", dmem_addr0, 30'h2);
        @(posedge clk);
        #1;
        check("ns_rsp", {rsp_valid0, rsp_err0}, 2'b10);
        check("ns_rdata", rsp_rdata0, 32'h0000_4321);

        fixed_delay = -1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int n0;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                            : 32'($urandom_range(0, 31));
            n0 = n_rsp;
            issue(1'($urandom_range(0, 1)), f3tab[$urandom_range(0, 9)], a, $urandom(), 1'b1);
            wait_rsp(n0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
